matrix_stream_loader: RTL and testbench
=======================================

MATRIX_STREAM_LOADER -- requirements
Module: matrix_stream_loader

Interface
REQ-001 Parameter MATRIX_N, default 3, matrix rows.
REQ-002 Parameter MATRIX_M, default 3, matrix columns.
REQ-003 Parameter WIDTH, default 16, element width in bits; SHALL be a multiple of 8.
REQ-004 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  block accepts a byte this cycle.
REQ-010 compute_done  input  1  consumer has finished with the presented matrices.
REQ-011 matrix_a  output  MATRIX_N*MATRIX_M*WIDTH  committed matrix A, flat bus.
REQ-012 matrix_b  output  MATRIX_N*MATRIX_M*WIDTH  committed matrix B, flat bus.
REQ-013 read_ready  output  1  committed matrices are valid for the consumer.
REQ-014 frame_err  output  1  one-cycle pulse on a checksum mismatch.
REQ-015 busy  output  1  a frame is in progress (LOAD or CHECK).

Function
REQ-016 A byte SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1.
REQ-017 Frame format: SYNC_BYTE, then P = 2*MATRIX_N*MATRIX_M*WIDTH/8 payload bytes (36 at the defaults), then 1 checksum byte.
REQ-018 Payload SHALL be MATRIX_N*MATRIX_M elements of A, then the same count of elements of B, each sent little-endian (LSB byte first).
REQ-019 Element index idx = r*MATRIX_M + c (row-major) SHALL map to bits [idx*WIDTH +: WIDTH] of its matrix bus.
REQ-020 The checksum SHALL be the XOR of all P payload bytes; the sync byte is excluded.
REQ-021 FSM states SHALL be HUNT, LOAD, CHECK and PRESENT.
REQ-022 HUNT: in_ready=1; an accepted byte equal to SYNC_BYTE moves to LOAD and clears the byte counter and running XOR; any other accepted byte is discarded.
REQ-023 LOAD: in_ready=1; each accepted byte is written into the staging registers and folded into the XOR; after byte P-1 the FSM moves to CHECK.
REQ-024 Inside LOAD, a byte equal to SYNC_BYTE SHALL be treated as ordinary data.
REQ-025 CHECK, accepted byte matches XOR: on the next cycle matrix_a/matrix_b take the staging values, read_ready=1, and the FSM is in PRESENT (latency 1 cycle after the checksum byte).
REQ-026 CHECK, accepted byte mismatches XOR: frame_err=1 for exactly one cycle on the next cycle, staging is discarded, matrix_a/matrix_b are unchanged, read_ready stays 0, and the FSM returns to HUNT.
REQ-027 PRESENT: in_ready=0 and read_ready=1; compute_done is sampled only in this state; the first cycle it is seen high, read_ready=0 and the FSM is in HUNT on the next cycle.
REQ-028 If compute_done is already high on the first PRESENT cycle, read_ready SHALL last exactly one cycle.
REQ-029 compute_done SHALL be ignored in HUNT, LOAD and CHECK.
REQ-030 matrix_a and matrix_b SHALL change only on a checksum-good commit and SHALL otherwise hold their values.
REQ-031 busy SHALL be 1 exactly when the state is LOAD or CHECK.
REQ-032 The byte counter SHALL be sized ceil(log2(P+1)) and SHALL NOT wrap inside a frame.
REQ-033 in_valid gaps inside a frame SHALL stall progress without error; there is no timeout.

Reset
REQ-034 While reset=0 at a rising edge: state=HUNT, counter=0, XOR=0, staging=0, matrix_a=0, matrix_b=0, read_ready=0, frame_err=0, busy=0.
REQ-035 in_ready SHALL be 0 in any cycle where reset is low.
REQ-036 Reset asserted mid-frame or in PRESENT SHALL abandon the frame and discard staging, with no frame_err pulse.

Verification
REQ-037 Good frame: A5, A elements 1..9, B = identity, correct XOR -> read_ready=1 one cycle after the checksum byte is accepted; matrix_a[15:0]=1, matrix_a[143:128]=9; matrix_b[15:0]=1, matrix_b[31:16]=0; in_ready=0; a compute_done pulse -> read_ready=0 and in_ready=1 on the next cycle.
REQ-038 Bad checksum (correct XOR ^ 8'h01) -> a single frame_err pulse; matrix_a=matrix_b=0 after reset (or the previous committed values); read_ready stays 0.
REQ-039 Bytes 00, FF, 3C before A5 followed by a good frame -> the garbage is discarded and the frame commits normally.
REQ-040 Random in_valid gaps throughout a good frame -> identical result to REQ-037; bytes offered during PRESENT are not consumed (in_ready=0).
REQ-041 Reset after 20 payload bytes, then a full good frame -> all outputs 0 during reset; the new frame commits correctly with no frame_err pulse.
REQ-042 Payload containing the element 16'h00A5 -> treated as data; matrix_a[15:0]=16'h00A5 after commit.

Source files
------------

// File: rtl/matrix_stream_loader_if.sv
// Stream-side and consumer-side signal bundle for matrix_stream_loader.
// Ports: in_data/in_valid/in_ready byte stream; compute_done consumer handshake;
//        matrix_a/matrix_b committed flat matrices; read_ready, frame_err, busy status.
interface matrix_stream_loader_if #(
  parameter int MATRIX_N = 3,
  parameter int MATRIX_M = 3,
  parameter int WIDTH    = 16
) ();
  localparam int MAT_W = MATRIX_N * MATRIX_M * WIDTH;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             compute_done;
  logic [MAT_W-1:0] matrix_a;
  logic [MAT_W-1:0] matrix_b;
  logic             read_ready;
  logic             frame_err;
  logic             busy;

  // Driven by the byte source / consumer.
  modport master (
    output in_data, in_valid, compute_done,
    input  in_ready, matrix_a, matrix_b, read_ready, frame_err, busy
  );

  // Implemented by the loader.
  modport slave (
    input  in_data, in_valid, compute_done,
    output in_ready, matrix_a, matrix_b, read_ready, frame_err, busy
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// Purpose: hunt for a sync byte, load two matrices from a byte stream, commit on good XOR checksum.
// Latency: matrices + read_ready one cycle after the checksum byte; frame_err pulse one cycle after a bad one.
// Backpressure: in_ready drops while matrices are presented, until compute_done is seen.
// Ports: clk, reset (sync, active-low); bus = matrix_stream_loader_if.slave carrying the byte
//        stream (in_data/in_valid/in_ready), compute_done, matrix_a/matrix_b, read_ready,
//        frame_err and busy.
module matrix_stream_loader #(
  parameter int         MATRIX_N  = 3,
  parameter int         MATRIX_M  = 3,
  parameter int         WIDTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic                   clk,
  input logic                   reset,
  matrix_stream_loader_if.slave bus
);

  localparam int ELEMS   = MATRIX_N * MATRIX_M;
  localparam int MAT_W   = ELEMS * WIDTH;
  localparam int STAGE_W = 2 * MAT_W;
  localparam int P       = STAGE_W / 8;
  localparam int CNT_W   = $clog2(P + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(P - 1);

  typedef enum logic [1:0] {HUNT, LOAD, CHECK, PRESENT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         xor_q;
  logic [STAGE_W-1:0] stage_q;
  logic [MAT_W-1:0]   mat_a_q, mat_b_q;
  logic               frame_err_q;

  logic in_ready_c;
  logic accept;
  logic is_sync;
  logic chk_ok;
  logic busy_c;
  logic read_ready_c;

  assign in_ready_c = reset && (state_q != PRESENT);
  assign accept     = bus.in_valid && in_ready_c;
  assign is_sync    = (bus.in_data == SYNC_BYTE);
  assign chk_ok     = (bus.in_data == xor_q);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy_c       = 1'b0;
    read_ready_c = 1'b0;
    case (state_q)
      HUNT: begin
        if (accept && is_sync) state_d = LOAD;
      end
      LOAD: begin
        busy_c = 1'b1;
        if (accept && (cnt_q == LAST)) state_d = CHECK;
      end
      CHECK: begin
        busy_c = 1'b1;
        if (accept) state_d = chk_ok ? PRESENT : HUNT;
      end
      PRESENT: begin
        read_ready_c = 1'b1;
        if (bus.compute_done) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  // Payload bytes shift in from the top; after P bytes the first byte sits at bits [7:0].
  // Because elements arrive LSB-first and row-major, A then B, the staging word is
  // already laid out as {matrix_b, matrix_a}.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      xor_q       <= '0;
      stage_q     <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (accept && is_sync) begin
            cnt_q <= '0;
            xor_q <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            stage_q <= {bus.in_data, stage_q[STAGE_W-1:8]};
            xor_q   <= xor_q ^ bus.in_data;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        CHECK: begin
          if (accept) begin
            if (chk_ok) begin
              mat_a_q <= stage_q[MAT_W-1:0];
              mat_b_q <= stage_q[STAGE_W-1:MAT_W];
            end else begin
              frame_err_q <= 1'b1;
              stage_q     <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.busy       = busy_c;
  assign bus.read_ready = read_ready_c;
  assign bus.frame_err  = frame_err_q;
  assign bus.matrix_a   = mat_a_q;
  assign bus.matrix_b   = mat_b_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Purpose: self-checking bench for matrix_stream_loader with a frame-level reference model.
// Latency: checks sample on the falling edge, half a cycle after the accepting rising edge.
// Backpressure: byte sender waits (bounded) on in_ready and inserts random in_valid gaps.
module tb_matrix_stream_loader;

  localparam int N = 3;
  localparam int M = 3;
  localparam int W = 16;
  localparam int E = N * M;
  localparam int MAT_W = E * W;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matrix_stream_loader_if #(.MATRIX_N(N), .MATRIX_M(M), .WIDTH(W)) bus ();

  matrix_stream_loader #(.MATRIX_N(N), .MATRIX_M(M), .WIDTH(W), .SYNC_BYTE(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int err_pulses = 0;

  logic [15:0]      el_a [E];
  logic [15:0]      el_b [E];
  logic [MAT_W-1:0] exp_a, exp_b;

  // Every cycle frame_err is high counts once, so a stuck pulse shows up as >1.
  always @(negedge clk) if (bus.frame_err === 1'b1) err_pulses++;

  task automatic check(input string tag, input logic [2*MAT_W-1:0] obs, input logic [2*MAT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference packing: element idx = r*M + c occupies bits [idx*W +: W].
  function automatic logic [MAT_W-1:0] pack(input logic [15:0] e [E]);
    logic [MAT_W-1:0] r = '0;
    for (int i = 0; i < E; i++) r[i*W +: W] = e[i];
    return r;
  endfunction

  // Offer one byte; returns on the falling edge after it was accepted.
  task automatic send(input logic [7:0] b, input int gap_pct);
    int n = 0;
    while ($urandom_range(99) < gap_pct) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 288'(n < 50), 288'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit corrupt, input int gap_pct);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    logic [15:0] e;
    send(SYNC, gap_pct);
    check("busy_in_load", 288'(bus.busy), 288'(1));
    for (int i = 0; i < 2 * E; i++) begin
      e = (i < E) ? el_a[i] : el_b[i - E];
      for (int j = 0; j < W / 8; j++) begin
        b = e[j*8 +: 8];
        x = x ^ b;
        send(b, gap_pct);
      end
    end
    send(corrupt ? (x ^ 8'h01) : x, gap_pct);
    if (!corrupt) begin
      exp_a = pack(el_a);
      exp_b = pack(el_b);
    end
  endtask

  task automatic check_result(input string tag, input bit corrupt);
    check({tag, "_read_ready"}, 288'(bus.read_ready), 288'(!corrupt));
    check({tag, "_frame_err"},  288'(bus.frame_err),  288'(corrupt));
    check({tag, "_matrix_a"},   288'(bus.matrix_a),   288'(exp_a));
    check({tag, "_matrix_b"},   288'(bus.matrix_b),   288'(exp_b));
    check({tag, "_busy"},       288'(bus.busy),       288'(0));
  endtask

  task automatic release_present(input string tag);
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    check({tag, "_rr_after_done"}, 288'(bus.read_ready), 288'(0));
    check({tag, "_rdy_after_done"}, 288'(bus.in_ready), 288'(1));
  endtask

  task automatic rand_elems();
    for (int i = 0; i < E; i++) begin
      el_a[i] = 16'($urandom);
      el_b[i] = 16'($urandom);
    end
  endtask

  initial begin
    int pulses0;
    bit bad;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.compute_done = 1'b0;
    exp_a = '0;
    exp_b = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", 288'(bus.in_ready), 288'(0));
    check("rst_read_ready", 288'(bus.read_ready), 288'(0));
    check("rst_frame_err", 288'(bus.frame_err), 288'(0));
    check("rst_busy", 288'(bus.busy), 288'(0));
    check("rst_matrix_a", 288'(bus.matrix_a), 288'(0));
    check("rst_matrix_b", 288'(bus.matrix_b), 288'(0));
    reset = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 288'(bus.in_ready), 288'(1));

    // Good frame: A = 1..9, B = identity
    for (int i = 0; i < E; i++) begin
      el_a[i] = 16'(i + 1);
      el_b[i] = (i % (M + 1) == 0) ? 16'd1 : 16'd0;
    end
    send_frame(1'b0, 0);
    check_result("good", 1'b0);
    check("good_a_lo", 288'(bus.matrix_a[15:0]), 288'(1));
    check("good_a_hi", 288'(bus.matrix_a[143:128]), 288'(9));
    check("good_b_00", 288'(bus.matrix_b[15:0]), 288'(1));
    check("good_b_01", 288'(bus.matrix_b[31:16]), 288'(0));
    check("good_in_ready", 288'(bus.in_ready), 288'(0));
    repeat (2) @(negedge clk);
    check("good_rr_hold", 288'(bus.read_ready), 288'(1));
    release_present("good");

    // Bad checksum: single pulse, matrices keep the previous commit
    rand_elems();
    pulses0 = err_pulses;
    send_frame(1'b1, 0);
    check_result("bad", 1'b1);
    @(negedge clk);
    check("bad_pulse_count", 288'(err_pulses - pulses0), 288'(1));
    check("bad_rr_after", 288'(bus.read_ready), 288'(0));
    check("bad_hunt_ready", 288'(bus.in_ready), 288'(1));

    // Garbage before sync is discarded
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h3C, 0);
    check("garbage_not_busy", 288'(bus.busy), 288'(0));
    rand_elems();
    send_frame(1'b0, 0);
    check_result("garbage", 1'b0);
    release_present("garbage");

    // Random in_valid gaps; bytes offered while presenting are refused
    rand_elems();
    send_frame(1'b0, 40);
    check_result("gaps", 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = SYNC;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("present_in_ready", 288'(bus.in_ready), 288'(0));
    end
    bus.in_valid = 1'b0;
    check("present_a_held", 288'(bus.matrix_a), 288'(exp_a));
    release_present("gaps");
    @(negedge clk);
    check("present_no_frame", 288'(bus.busy), 288'(0));

    // Reset after 20 payload bytes, then a fresh good frame
    pulses0 = err_pulses;
    send(SYNC, 0);
    for (int k = 0; k < 20; k++) send(8'($urandom), 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 288'(bus.in_ready), 288'(0));
    check("midrst_busy", 288'(bus.busy), 288'(0));
    check("midrst_read_ready", 288'(bus.read_ready), 288'(0));
    check("midrst_matrix_a", 288'(bus.matrix_a), 288'(0));
    check("midrst_matrix_b", 288'(bus.matrix_b), 288'(0));
    exp_a = '0;
    exp_b = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rand_elems();
    send_frame(1'b0, 10);
    check_result("after_rst", 1'b0);
    check("after_rst_no_err", 288'(err_pulses - pulses0), 288'(0));
    release_present("after_rst");

    // Sync-valued data inside payload; compute_done held high throughout (ignored until presenting)
    rand_elems();
    el_a[0] = 16'h00A5;
    el_b[3] = 16'hA5A5;
    bus.compute_done = 1'b1;
    send_frame(1'b0, 0);
    check_result("sync_data", 1'b0);
    check("sync_data_a0", 288'(bus.matrix_a[15:0]), 288'(16'h00A5));
    @(negedge clk);
    check("one_cycle_rr", 288'(bus.read_ready), 288'(0));
    bus.compute_done = 1'b0;

    // Randomized frames, good or bad
    for (int k = 0; k < 6; k++) begin
      rand_elems();
      bad = 1'($urandom_range(0, 1));
      send_frame(bad, int'($urandom_range(0, 50)));
      check_result("rand", bad);
      if (!bad) release_present("rand");
      else @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
